// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8N1 UART serializer in the clk_sys domain.
// Ports:
//   clk_sys   - system clock (only clock)
//   rst       - synchronous active-high reset
//   tx_data   - byte to queue, sampled only when pushed
//   tx_valid  - push request; each high cycle with tx_ready=1 queues one byte
//   tx_ready  - FIFO not full (combinational from registered count)
//   txd       - registered serial output, idle high
//   busy      - frame in progress or bytes still queued
//   drop      - one-cycle pulse when a byte was offered while the FIFO was full
module uart_tx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       clk_sys,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       txd,
    output logic       busy,
    output logic       drop
);

    localparam int unsigned BAUD_W  = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned COUNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [BAUD_W-1:0]  baud_q, baud_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [7:0]         shift_q, shift_d;
    logic               txd_q, txd_d;
    logic               drop_q, drop_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [7:0]         mem_q [FIFO_DEPTH];

    logic push;
    logic pop;
    logic bit_end;
    logic fifo_full;

    assign fifo_full = (count_q == COUNT_W'(FIFO_DEPTH));
    assign tx_ready  = ~fifo_full;
    assign busy      = (state_q != IDLE) || (count_q != '0);
    assign txd       = txd_q;
    assign drop      = drop_q;

    // Next-state, FIFO bookkeeping and serializer datapath.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        txd_d     = txd_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        pop       = 1'b0;

        push    = tx_valid && !fifo_full;
        drop_d  = tx_valid && fifo_full;
        bit_end = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

        case (state_q)
            IDLE: begin
                txd_d = 1'b1;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    txd_d   = 1'b0;
                    baud_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_d    = '0;
                    txd_d     = shift_q[0];
                    bit_idx_d = 3'd0;
                    state_d   = DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_idx_q != 3'd7) begin
                        shift_d   = shift_q >> 1;
                        txd_d     = shift_q[1];
                        bit_idx_d = bit_idx_q + 3'd1;
                    end else begin
                        txd_d   = 1'b1;
                        state_d = STOP;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_d = '0;
                    // Chain straight into the next start bit when more bytes wait.
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        txd_d   = 1'b0;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + COUNT_W'(1);
            2'b01:   count_d = count_q - COUNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State and control registers.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            txd_q     <= 1'b1;
            drop_q    <= 1'b0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
            drop_q    <= drop_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
        end
    end

    // FIFO storage; contents are don't-care while count is zero, so no reset.
    always_ff @(posedge clk_sys) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= tx_data;
        end
    end

endmodule
